hex_7seg_scan_driver: RTL

//  Time-multiplexed driver for a DIGITS-wide common-segment hex 7-seg display.

---
 rtl/hex_7seg_scan_driver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hex_7seg_scan_driver.sv
// Time-multiplexed hex 7-segment scan driver with a frame-synchronous shadow register.
// Optional decimal-point support is enabled by defining HEX7SEG_DP_EN.
module hex_7seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lz_blank,
`ifdef HEX7SEG_DP_EN
    input  logic [DIGITS-1:0]     dp,
    output logic                  seg_dp,
`endif
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] EN_OFF  = {DIGITS{ACTIVE_LOW}};

    if (DIGITS < 1 || DIGITS > 8 || CLK_DIV < 1) begin : g_param_check
        $error("hex_7seg_scan_driver: DIGITS must be 1..8 and CLK_DIV >= 1");
    end

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    logic [CW-1:0]       div_cnt_q, div_cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, pending_q, shifted;
    logic                pend_v_q;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                frame_done_q;
    logic                tick, last, boundary, blank;

    always_comb begin
        tick       = (div_cnt_q == CW'(CLK_DIV - 1));
        last       = (idx_q == IW'(DIGITS - 1));
        boundary   = tick && last;
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (tick) idx_d = last ? '0 : idx_q + 1'b1;
        // Digit k's nibble lands in [3:0]; an all-zero remainder means k is a leading zero.
        shifted    = shadow_q >> {idx_q, 2'b00};
        blank      = lz_blank && (idx_q != '0) && (shifted == '0);
        seg_d      = (blank ? 7'h00 : hex_to_seg(shifted[3:0])) ^ SEG_OFF;
        digit_en_d = (DIGITS'(1) << idx_q) ^ EN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            seg_q        <= SEG_OFF;
            digit_en_q   <= EN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= boundary;
            if (load) pending_q <= value;
            // A load coinciding with the boundary bypasses pending straight into the new frame.
            if (boundary) begin
                if (load)          shadow_q <= value;
                else if (pend_v_q) shadow_q <= pending_q;
                pend_v_q <= 1'b0;
            end else if (load) begin
                pend_v_q <= 1'b1;
            end
        end
    end

    assign seg        = seg_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

`ifdef HEX7SEG_DP_EN
    logic [DIGITS-1:0] dp_pend_q, dp_shadow_q, dp_shifted;
    logic              seg_dp_q;

    always_comb dp_shifted = dp_shadow_q >> idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_pend_q   <= '0;
            dp_shadow_q <= '0;
            seg_dp_q    <= ACTIVE_LOW;
        end else begin
            seg_dp_q <= dp_shifted[0] ^ ACTIVE_LOW;
            if (load) dp_pend_q <= dp;
            if (boundary) begin
                if (load)          dp_shadow_q <= dp;
                else if (pend_v_q) dp_shadow_q <= dp_pend_q;
            end
        end
    end

    assign seg_dp = seg_dp_q;
`endif

endmodule
